// File: rtl/mux_sel_sequencer_pkg.sv
// mux_sel_sequencer_pkg: shared widths, state encoding and bit-order constants.
package mux_sel_sequencer_pkg;
    localparam int WORD_W = 8;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;
endpackage

// File: rtl/mux_sel_sequencer_hold_div.sv
// hold_div: counts 0..DIV-1 while enabled and strobes tc on the last count.
module hold_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    assign tc = en && cnt == CW'(DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: latches a word and walks the 8:1 mux select across it, DIV clocks per bit.
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              msb_first,
    input  logic              abort,
    output logic [WORD_W-1:0] word_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              bit_o,
    output logic              busy,
    output logic              done
);
    state_t state, state_nx;
    logic order, tc, last, accept, step, hold_clr, hold_en;

    assign hold_en  = state == SHIFT;
    assign hold_clr = state != SHIFT || abort;
    assign last     = order == MSB_FIRST ? sel_o == '0 : sel_o == SEL_W'(WORD_W - 1);
    assign accept   = state == IDLE && in_valid && !abort;
    assign step     = state == SHIFT && tc && !last && !abort;

    hold_div #(.DIV(DIV)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clear(hold_clr),
        .en   (hold_en),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = abort ? IDLE : (tc && last) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == IDLE;
        busy     = state == SHIFT;
        done     = state == DONE;
        bit_o    = word_o[sel_o];
    end

    // Terminal index is tested before stepping, so sel_o never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_o <= '0;
            sel_o  <= '0;
            order  <= LSB_FIRST;
        end else if (accept) begin
            word_o <= in_data;
            order  <= msb_first;
            sel_o  <= msb_first == MSB_FIRST ? SEL_W'(WORD_W - 1) : '0;
        end else if (step) begin
            sel_o  <= order == MSB_FIRST ? sel_o - 1'b1 : sel_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: two instances (DIV=1, DIV=3) checked every cycle against a frame-timeline model.
module tb_mux_sel_sequencer;
    logic clk = 0, rst = 1;
    logic in_valid = 0, msb_first = 0, abort = 0;
    logic [7:0] in_data = 0;
    logic rdy[2], bt[2], bsy[2], dn[2];
    logic [7:0] wo[2];
    logic [2:0] so[2];
    int total = 0, bad = 0;

    int m_mode[2], m_t[2];
    logic [7:0] m_word[2];
    logic [2:0] m_sel[2];
    logic m_order[2];

    always #5 clk = ~clk;

    mux_sel_sequencer #(.DIV(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .msb_first(msb_first), .abort(abort), .word_o(wo[0]), .sel_o(so[0]), .bit_o(bt[0]),
        .busy(bsy[0]), .done(dn[0])
    );
    mux_sel_sequencer #(.DIV(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .msb_first(msb_first), .abort(abort), .word_o(wo[1]), .sel_o(so[1]), .bit_o(bt[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    // Model: mode 0 idle / 1 shift / 2 done; t = cycles elapsed in shift, select = t/DIV from the start end.
    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                m_mode[g] <= 0; m_t[g] <= 0; m_word[g] <= 0; m_sel[g] <= 0; m_order[g] <= 0;
            end else if (m_mode[g] == 0) begin
                if (!abort && in_valid) begin
                    m_mode[g] <= 1; m_t[g] <= 0; m_word[g] <= in_data;
                    m_order[g] <= msb_first; m_sel[g] <= msb_first ? 3'd7 : 3'd0;
                end
            end else if (m_mode[g] == 1) begin
                if (abort) m_mode[g] <= 0;
                else if (m_t[g] + 1 == 8 * (g ? 3 : 1)) m_mode[g] <= 2;
                else begin
                    m_t[g] <= m_t[g] + 1;
                    m_sel[g] <= m_order[g] ? 3'(7 - (m_t[g] + 1) / (g ? 3 : 1))
                                           : 3'((m_t[g] + 1) / (g ? 3 : 1));
                end
            end else m_mode[g] <= 0;
        end
    end

    task automatic chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, a, e);
        end
    endtask

    task automatic check_model();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("u%0d.in_ready", g), int'(rdy[g]), int'(m_mode[g] == 0));
            chk($sformatf("u%0d.busy", g), int'(bsy[g]), int'(m_mode[g] == 1));
            chk($sformatf("u%0d.done", g), int'(dn[g]), int'(m_mode[g] == 2));
            chk($sformatf("u%0d.word_o", g), int'(wo[g]), int'(m_word[g]));
            chk($sformatf("u%0d.sel_o", g), int'(so[g]), int'(m_sel[g]));
            chk($sformatf("u%0d.bit_o", g), int'(bt[g]), int'(m_word[g][m_sel[g]]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic send(input logic [7:0] d, input logic m);
        in_valid = 1; in_data = d; msb_first = m;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(rdy[0] && rdy[1]), 1);
    endtask

    task automatic run_div1(input logic [7:0] d, input logic m, input logic [7:0] want);
        logic [7:0] bits = 0;
        send(d, m);
        for (int i = 0; i < 8; i++) begin
            bits[i] = bt[0];
            if (i < 7) tick();
        end
        tick();
        chk("div1_done_at_8", int'(dn[0]), 1);
        tick();
        chk("div1_ready_at_9", int'(rdy[0]), 1);
        chk("div1_bits", int'(bits), int'(want));
        wait_idle();
    endtask

    initial begin
        logic [7:0] bits;
        repeat (2) @(negedge clk);
        check_model();
        chk("reset_word", int'(wo[0]), 0);
        chk("reset_ready", int'(rdy[1]), 1);
        rst = 0;
        tick();
        run_div1(8'b00010111, 1'b0, 8'h17);
        run_div1(8'b00010111, 1'b1, 8'hE8);
        // DIV=3 instance, each select held three cycles
        bits = 0;
        send(8'hA5, 1'b0);
        for (int i = 0; i < 24; i++) begin
            bits[i/3] = bt[1];
            chk("div3_sel_hold", int'(so[1]), i / 3);
            if (i < 23) tick();
        end
        tick();
        chk("div3_done_at_24", int'(dn[1]), 1);
        tick();
        chk("div3_done_single", int'(dn[1]), 0);
        chk("div3_bits", int'(bits), 8'hA5);
        wait_idle();
        // in_valid held through a frame, msb_first toggling mid-frame
        send(8'hFF, 1'b0);
        in_valid = 1; in_data = 8'h3C;
        for (int i = 1; i <= 10; i++) begin
            msb_first = ~msb_first;
            tick();
            if (i == 8) chk("hold_done", int'(dn[0]), 1);
            if (i < 9) chk("hold_not_ready", int'(rdy[0]), 0);
        end
        chk("hold_accept_next", int'(wo[0]), 8'h3C);
        in_valid = 0;
        wait_idle();
        // abort at sel 4, then abort with in_valid in IDLE
        send(8'h5A, 1'b0);
        repeat (4) tick();
        chk("abort_sel_before", int'(so[0]), 4);
        abort = 1;
        tick();
        chk("abort_ready", int'(rdy[0]), 1);
        chk("abort_sel_held", int'(so[0]), 4);
        chk("abort_word_held", int'(wo[0]), 8'h5A);
        in_valid = 1; in_data = 8'h11;
        tick();
        chk("abort_blocks_accept", int'(wo[0]), 8'h5A);
        abort = 0; in_valid = 0;
        // async reset between edges
        send(8'hC3, 1'b1);
        repeat (3) tick();
        #1 rst = 1;
        #1;
        check_model();
        chk("async_rst_word", int'(wo[0]), 0);
        chk("async_rst_ready", int'(rdy[0]), 1);
        #1 rst = 0;
        tick();
        send(8'h96, 1'b0);
        wait_idle();
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            msb_first = 1'($urandom_range(0, 1));
            abort = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 0; abort = 0; in_valid = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream driver for the 8:1 bit-select mux.
- Accepts an 8-bit word through a valid/ready handshake and latches it onto the mux data bus (word_o).
- Steps the 3-bit select (sel_o) through all eight positions, LSB-first or MSB-first, holding each for DIV clocks, then pulses done.
- Also provides the selected bit locally (bit_o), so the bench can check the mux output against it.

Parameters:
- WORD_W, 8, data word width; fixed at 8 to match the 8:1 mux.
- SEL_W, 3, select width; equals log2(WORD_W).
- DIV, 1, clocks each select value is held; legal range 1..256.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, in_data is valid.
- in_data, input, 8, word to serialise.
- in_ready, output, 1, block can accept a word.
- msb_first, input, 1, bit order; sampled only at word acceptance.
- abort, input, 1, synchronous frame cancel.
- word_o, output, 8, latched word; drives the mux data input.
- sel_o, output, 3, current select; drives the mux select.
- bit_o, output, 1, word_o[sel_o], combinational from registers.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, word_o=0, sel_o=0, prescaler=0, order flag=0.
  - Therefore busy=0, done=0, bit_o=0, in_ready=1.
- States:
  - IDLE: in_ready=1, busy=0.
  - SHIFT: in_ready=0, busy=1.
  - DONE: in_ready=0, busy=0, done=1.
- IDLE: on an edge with in_valid=1, the word is accepted:
  - word_o<=in_data, order flag<=msb_first.
  - sel_o<=msb_first ? 7 : 0, prescaler<=0, state<=SHIFT.
  - Without in_valid: all registers hold, and sel_o keeps its last value so the mux output stays stable.
- SHIFT: the prescaler counts 0..DIV-1 every clock. When prescaler==DIV-1:
  - Prescaler returns to 0.
  - If sel_o is the last index (7 for LSB-first, 0 for MSB-first): state<=DONE, sel_o holds.
  - Otherwise sel_o increments (LSB-first) or decrements (MSB-first).
  - Each select value is therefore held exactly DIV cycles.
- DONE: lasts exactly 1 cycle, then IDLE unconditionally. in_valid is not accepted during DONE.
- Timing: word accepted at edge k → SHIFT occupies cycles k..k+8*DIV-1 → done=1 in cycle k+8*DIV → in_ready=1 from cycle k+8*DIV+1.
  - Maximum throughput is one word per 8*DIV+2 cycles.
- bit_o has no added latency: it changes in the same cycle as word_o or sel_o.
- in_data and msb_first are ignored outside the accepting IDLE edge. Changes mid-frame have no effect.
- abort=1 on an edge in SHIFT or DONE: state<=IDLE, prescaler<=0, no done pulse.
  - word_o and sel_o hold their values.
  - abort in IDLE has priority over acceptance: no word is taken that cycle.
- rst asserted mid-frame: all registers clear immediately and no done is generated. After release, the block is in IDLE with in_ready=1.
- Width rules:
  - Prescaler width is max(1, clog2(DIV)).
  - sel_o never wraps: the terminal compare happens before increment or decrement, so 7→0 and 0→7 never occur.

Decomposition:
- Shared package holds:
  - WORD_W=8 and SEL_W=3 constants.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - LSB_FIRST=1'b0 and MSB_FIRST=1'b1 constants.
- One sub-module is natural: hold_div.
  - Parameterised by DIV, with clear and enable inputs.
  - Produces a terminal-count strobe.
- Select stepping and the FSM stay in mux_sel_sequencer.
- The 8:1 mux itself is not instantiated here. word_o and sel_o connect to it at the next level up.

Test Plan:
1. DIV=1, msb_first=0, in_data=8'b00010111 accepted at edge k → sel_o=0..7 in cycles k..k+7; bit_o sequence 1,1,1,0,1,0,0,0; done=1 only in cycle k+8; in_ready=1 from k+9.
2. DIV=1, msb_first=1, same word → sel_o=7..0; bit_o sequence 0,0,0,1,0,1,1,1; done in cycle k+8.
3. DIV=3, msb_first=0, in_data=8'hA5 → each sel_o held exactly 3 cycles; bit_o=1,0,1,0,0,1,0,1; done in cycle k+24, single-cycle.
4. in_valid held high with 8'h3C during a frame of 8'hFF → in_ready=0 throughout SHIFT and DONE; 8'h3C accepted on the first IDLE edge; toggling msb_first mid-frame does not change the direction.
5. abort asserted when sel_o=4 (DIV=1, LSB-first) → IDLE next cycle, no done pulse, sel_o=4 and word_o held, in_ready=1; abort together with in_valid in IDLE → no acceptance.
6. rst pulsed between clock edges mid-SHIFT → word_o=0, sel_o=0, busy=0, done=0, in_ready=1 immediately, before the next edge; normal frame completes after release.
